mc_control_fsm: RTL
===================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle control unit for the single-issue integer datapath. Consumes the decoded
//  fields (opcode/func3/func7b50) and the EX-stage done flag from the datapath; sequences
//  IF->ID->EX->WB by driving all datapath enables/selects. Supports RV32I OP/OP-IMM and
//  RV32M MUL group; everything else (incl. DIV/REM until QRU lands) traps.
// PARAMETERS
//  PCMUX_N     2   pcmux input count; pcmuxctl width = $clog2(PCMUX_N)
//  IFURES_N    2   ifuresmux input count; ifuresctl width = $clog2(IFURES_N)
//  MU_TIMEOUT  64  max MWAIT cycles before trap (>=2)
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst_n      in   1   synchronous active-low reset
//  run        in   1   1 = leave IDLE / keep fetching; sampled in IDLE and WB only
//  opcode     in   7   instr[6:0]
//  func3      in   3   instr[14:12]
//  func7b50   in   2   {instr[30],instr[25]}
//  exdone     in   1   EX valid from datapath (MU done or 1 for ALU)
//  pcmuxctl   out  clog2(PCMUX_N)   always 0 (pc+4)
//  pcnextctl  out  1   pc update strobe
//  instrre    out  1   instruction read enable
//  regre      out  1   regfile read enable
//  regwe      out  1   regfile write enable
//  bmuxctl    out  1   1 = rs2, 0 = immediate (= opcode[5] latched)
//  aluctl     out  4   ALU op
//  mulstart   out  1   MU start pulse
//  mulctl     out  2   MU op = func3[1:0]
//  ifuresctl  out  clog2(IFURES_N)  0 = ALU, 1 = MU
//  trap       out  1   sticky illegal/timeout flag
//  instret    out  32  retired-instruction counter
// BEHAVIOUR
//  States: IDLE, FETCH, DECODE, EXEC, MSTART, MWAIT, WB, TRAP. Enables are Moore outputs of state.
//  Reset (rst_n=0 at posedge): state=IDLE, all enables 0, aluctl/mulctl/ifuresctl/bmuxctl=0,
//   trap=0, instret=0. PC is not reset here.
//  IDLE: no enables; run=1 -> FETCH.
//  FETCH: instrre=1 (imem clocked, instr valid next cycle) -> DECODE.
//  DECODE: regre=1; classify and latch bmuxctl/aluctl/mulctl/ifuresctl, held until WB exits.
//   0110011, func7b50=00/10 -> ALU R; 0010011 -> ALU I; 0110011, func7b50=01, func3[2]=0 -> MU;
//   any other combination -> TRAP. ALU -> EXEC, MU -> MSTART.
//  aluctl: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND.
//   func3 000: SUB iff R and func7b50[1]; 101: SRA iff func7b50[1] (R and I); ADDI never SUB.
//   OP-IMM func3=001 with func7b50[1]=1 -> TRAP.
//  EXEC: ifuresctl=0; -> WB (exdone ignored, ALU combinational).
//  MSTART: mulstart=1 exactly one cycle, ifuresctl=1 -> MWAIT, timeout cnt=0.
//  MWAIT: mulstart=0; exdone=1 -> WB; else cnt++; cnt reaches MU_TIMEOUT-1 without exdone -> TRAP.
//  WB: regwe=1, pcnextctl=1, pcmuxctl=0, latched ctl held; instret+=1 (wraps at 2^32).
//   run=1 -> FETCH, run=0 -> IDLE.
//  TRAP: all enables 0, trap=1; exits only via reset. No regwe/pcnextctl for trapping instr.
//  Latency: ALU instr 4 cycles (FETCH..WB); MU instr 4+k cycles, k = MWAIT cycles incl. exdone cycle.
//  Reset asserted in any state (incl. MWAIT mid-multiply) wins: next state IDLE, no write issued.
//  exdone asserted outside MWAIT is ignored.
// TESTING
//  reset, run=1, ADDI x1,x0,5 (op 0010011,f3 000) -> instrre@c1,regre@c2,aluctl=0,bmuxctl=0,regwe+pcnextctl@c4, instret=1
//  SUB R (0110011,f3 000,f7b50=10) -> aluctl=1,bmuxctl=1; SRAI (f3 101,f7b50=10) -> aluctl=7,bmuxctl=0
//  MULHU (f7b50=01,f3 011), exdone 5 cycles after mulstart -> mulstart 1 cycle, mulctl=3, ifuresctl=1, WB next cycle
//  DIV (f7b50=01,f3 100) or opcode 0000011 -> trap=1 after DECODE, no regwe/pcnextctl, stays until rst_n=0
//  MUL with exdone never asserted, MU_TIMEOUT=8 -> trap=1 after 8 MWAIT cycles
//  rst_n=0 during MWAIT -> IDLE next cycle, instret=0, no regwe; run=0 at WB -> IDLE, no further instrre

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the single-issue integer datapath.
// Walks each instruction through FETCH -> DECODE -> EXEC/MSTART+MWAIT -> WB.
// Datapath enables are decoded from the current state. The mux and operation
// selects are captured in DECODE and then held until the next legal decode.
// An illegal instruction, or a multiply that never reports done, parks the
// unit in TRAP until reset.
module mc_control_fsm #(
    parameter int PCMUX_N    = 2,
    parameter int IFURES_N   = 2,
    parameter int MU_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    input  logic [6:0]                    opcode,
    input  logic [2:0]                    func3,
    input  logic [1:0]                    func7b50,
    input  logic                          exdone,
    output logic [$clog2(PCMUX_N)-1:0]    pcmuxctl,
    output logic                          pcnextctl,
    output logic                          instrre,
    output logic                          regre,
    output logic                          regwe,
    output logic                          bmuxctl,
    output logic [3:0]                    aluctl,
    output logic                          mulstart,
    output logic [1:0]                    mulctl,
    output logic [$clog2(IFURES_N)-1:0]   ifuresctl,
    output logic                          trap,
    output logic [31:0]                   instret
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MSTART = 3'd4;
    localparam logic [2:0] S_MWAIT  = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // The timeout counter must be able to hold MU_TIMEOUT-1.
    localparam int             CW       = (MU_TIMEOUT > 2) ? $clog2(MU_TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(MU_TIMEOUT - 1);
    localparam int             IW       = $clog2(IFURES_N);

    logic [2:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [31:0]   instret_reg;
    logic          bmux_reg;
    logic [3:0]    alu_reg;
    logic [1:0]    mul_reg;
    logic [IW-1:0] ifures_reg;

    logic          is_op, is_imm;
    logic          dec_alu, dec_mu;
    logic [3:0]    dec_aluctl;

    assign is_op  = (opcode == OPC_OP);
    assign is_imm = (opcode == OPC_OP_IMM);

    // Instruction classification and ALU operation select from the decoded fields.
    always_comb begin
        dec_alu = 1'b0;
        dec_mu  = 1'b0;
        if (is_op && !func7b50[0]) begin
            dec_alu = 1'b1;
        end else if (is_imm && !(func3 == 3'b001 && func7b50[1])) begin
            dec_alu = 1'b1;
        end else if (is_op && func7b50 == 2'b01 && !func3[2]) begin
            dec_mu = 1'b1;
        end

        dec_aluctl = ALU_ADD;
        case (func3)
            3'b000:  dec_aluctl = (is_op && func7b50[1]) ? ALU_SUB : ALU_ADD;
            3'b001:  dec_aluctl = ALU_SLL;
            3'b010:  dec_aluctl = ALU_SLT;
            3'b011:  dec_aluctl = ALU_SLTU;
            3'b100:  dec_aluctl = ALU_XOR;
            3'b101:  dec_aluctl = func7b50[1] ? ALU_SRA : ALU_SRL;
            3'b110:  dec_aluctl = ALU_OR;
            default: dec_aluctl = ALU_AND;
        endcase
    end

    // Next-state sequencing.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (run) state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (dec_mu)       state_next = S_MSTART;
                else if (dec_alu) state_next = S_EXEC;
                else              state_next = S_TRAP;
            end
            S_EXEC:   state_next = S_WB;
            S_MSTART: state_next = S_MWAIT;
            S_MWAIT: begin
                if (exdone)                  state_next = S_WB;
                else if (cnt_reg == CNT_LAST) state_next = S_TRAP;
            end
            S_WB:     state_next = run ? S_FETCH : S_IDLE;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_IDLE;
        endcase
    end

    // State, captured selects, multiply timeout and retire counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            instret_reg <= '0;
            bmux_reg    <= 1'b0;
            alu_reg     <= ALU_ADD;
            mul_reg     <= 2'b00;
            ifures_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE && (dec_alu || dec_mu)) begin
                bmux_reg   <= opcode[5];
                alu_reg    <= dec_aluctl;
                mul_reg    <= func3[1:0];
                ifures_reg <= dec_mu ? IW'(1) : '0;
            end
            if (state_reg == S_MSTART) begin
                cnt_reg <= '0;
            end else if (state_reg == S_MWAIT && !exdone) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == S_WB) begin
                instret_reg <= instret_reg + 32'd1;
            end
        end
    end

    // Datapath strobes decoded from the current state.
    always_comb begin
        instrre   = (state_reg == S_FETCH);
        regre     = (state_reg == S_DECODE);
        mulstart  = (state_reg == S_MSTART);
        regwe     = (state_reg == S_WB);
        pcnextctl = (state_reg == S_WB);
        trap      = (state_reg == S_TRAP);
        pcmuxctl  = '0;
        bmuxctl   = bmux_reg;
        aluctl    = alu_reg;
        mulctl    = mul_reg;
        ifuresctl = ifures_reg;
        instret   = instret_reg;
    end

endmodule
